cajero_param: RTL and testbench

Parametrised ATM transaction controller: the synthesisable successor to the fixed-width cajero stimulus setup. It takes a card-present level, BCD PIN digits one strobe at a time, a transaction type and an amount. It verifies the PIN against a configured value with a configurable attempt limit and permanent lockout, then applies a deposit or withdrawal to an internal balance register. It sits between the keypad/card front end and the cash dispenser.

---
 rtl/cajero_param_if.sv | 36 +++
 rtl/cajero_param.sv | 129 ++++++++++++
 tb/tb_cajero_param.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/cajero_param_if.sv
// rtl/cajero_param_if.sv - card/keypad/amount bus between the ATM front end and cajero_param
interface cajero_param_if #(
   parameter int PIN_DIGITS = 4,
   parameter int MONTO_W    = 32,
   parameter int BALANCE_W  = 64
);
   logic                    TARJETA_RECIBIDA;
   logic                    TIPO_TRANS;
   logic [3:0]              DIGITO;
   logic                    DIGITO_STB;
   logic [4*PIN_DIGITS-1:0] PIN;
   logic [MONTO_W-1:0]      MONTO;
   logic                    MONTO_STB;
   logic [BALANCE_W-1:0]    BALANCE_INICIAL;
   logic [BALANCE_W-1:0]    BALANCE;
   logic                    BALANCE_ACTUALIZADO;
   logic                    ENTREGAR_DINERO;
   logic                    FONDOS_INSUFICIENTES;
   logic                    PIN_INCORRECTO;
   logic                    ADVERTENCIA;
   logic                    BLOQUEO;

   modport master (
      output TARJETA_RECIBIDA, TIPO_TRANS, DIGITO, DIGITO_STB, PIN, MONTO, MONTO_STB,
             BALANCE_INICIAL,
      input  BALANCE, BALANCE_ACTUALIZADO, ENTREGAR_DINERO, FONDOS_INSUFICIENTES,
             PIN_INCORRECTO, ADVERTENCIA, BLOQUEO
   );

   modport slave (
      input  TARJETA_RECIBIDA, TIPO_TRANS, DIGITO, DIGITO_STB, PIN, MONTO, MONTO_STB,
             BALANCE_INICIAL,
      output BALANCE, BALANCE_ACTUALIZADO, ENTREGAR_DINERO, FONDOS_INSUFICIENTES,
             PIN_INCORRECTO, ADVERTENCIA, BLOQUEO
   );
endinterface

// File: rtl/cajero_param.sv
// rtl/cajero_param.sv - ATM controller: PIN check with lockout, deposit/withdrawal on a balance
module cajero_param #(
   parameter int PIN_DIGITS   = 4,
   parameter int MAX_INTENTOS = 3,
   parameter int MONTO_W      = 32,
   parameter int BALANCE_W    = 64
) (
   input logic           clk,
   input logic           rst,
   cajero_param_if.slave bus
);
   localparam int PIN_W = 4 * PIN_DIGITS;
   localparam int CNT_W = $clog2(PIN_DIGITS + 1);
   localparam int INT_W = $clog2(MAX_INTENTOS + 1);

   typedef enum logic [2:0] {
      IDLE, PIN_ENTRY, CHECK, WAIT_MONTO, EXEC, FIN, BLOQUEADO
   } state_t;

   state_t               state;
   logic                 cargado;
   logic                 tipo;
   logic [CNT_W-1:0]     dig_cnt;
   logic [INT_W-1:0]     intentos;
   logic [PIN_W-1:0]     shreg;
   logic [MONTO_W-1:0]   monto_q;
   logic [BALANCE_W-1:0] balance;
   logic                 actualizado, entregar, fondos, pin_mal, advertencia, bloqueo;

   logic [BALANCE_W-1:0] monto_ext;
   logic [BALANCE_W:0]   suma;
   logic [INT_W-1:0]     intentos_nxt;

   assign monto_ext    = BALANCE_W'(monto_q);
   assign suma         = {1'b0, balance} + {1'b0, monto_ext};
   assign intentos_nxt = intentos + INT_W'(1);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         cargado     <= 1'b0;
         tipo        <= 1'b0;
         dig_cnt     <= '0;
         intentos    <= '0;
         shreg       <= '0;
         monto_q     <= '0;
         balance     <= '0;
         actualizado <= 1'b0;
         entregar    <= 1'b0;
         fondos      <= 1'b0;
         pin_mal     <= 1'b0;
         advertencia <= 1'b0;
         bloqueo     <= 1'b0;
      end else begin
         actualizado <= 1'b0;
         entregar    <= 1'b0;
         fondos      <= 1'b0;
         pin_mal     <= 1'b0;
         // The load edge after reset does nothing else, so a card already present waits one cycle.
         if (!cargado) begin
            balance <= bus.BALANCE_INICIAL;
            cargado <= 1'b1;
         end else begin
            case (state)
               IDLE: if (bus.TARJETA_RECIBIDA) begin
                  tipo    <= bus.TIPO_TRANS;
                  dig_cnt <= '0;
                  state   <= PIN_ENTRY;
               end
               PIN_ENTRY: if (!bus.TARJETA_RECIBIDA) begin
                  state <= IDLE;
               end else if (bus.DIGITO_STB) begin
                  shreg   <= {shreg[PIN_W-5:0], bus.DIGITO};
                  dig_cnt <= dig_cnt + CNT_W'(1);
                  if (dig_cnt == CNT_W'(PIN_DIGITS - 1)) state <= CHECK;
               end
               CHECK: if (!bus.TARJETA_RECIBIDA) begin
                  state <= IDLE;
               end else if (shreg == bus.PIN) begin
                  intentos    <= '0;
                  advertencia <= 1'b0;
                  state       <= WAIT_MONTO;
               end else begin
                  intentos <= intentos_nxt;
                  pin_mal  <= 1'b1;
                  if (intentos_nxt == INT_W'(MAX_INTENTOS - 1)) advertencia <= 1'b1;
                  if (intentos_nxt == INT_W'(MAX_INTENTOS)) begin
                     bloqueo <= 1'b1;
                     state   <= BLOQUEADO;
                  end else begin
                     dig_cnt <= '0;
                     state   <= PIN_ENTRY;
                  end
               end
               WAIT_MONTO: if (!bus.TARJETA_RECIBIDA) begin
                  state <= IDLE;
               end else if (bus.MONTO_STB) begin
                  monto_q <= bus.MONTO;
                  state   <= EXEC;
               end
               EXEC: begin
                  if (!tipo) begin
                     balance     <= suma[BALANCE_W] ? '1 : suma[BALANCE_W-1:0];
                     actualizado <= 1'b1;
                  end else if (monto_ext <= balance) begin
                     balance     <= balance - monto_ext;
                     actualizado <= 1'b1;
                     entregar    <= 1'b1;
                  end else begin
                     fondos <= 1'b1;
                  end
                  state <= FIN;
               end
               FIN: if (!bus.TARJETA_RECIBIDA) state <= IDLE;
               BLOQUEADO: bloqueo <= 1'b1;
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign bus.BALANCE              = balance;
   assign bus.BALANCE_ACTUALIZADO  = actualizado;
   assign bus.ENTREGAR_DINERO      = entregar;
   assign bus.FONDOS_INSUFICIENTES = fondos;
   assign bus.PIN_INCORRECTO       = pin_mal;
   assign bus.ADVERTENCIA          = advertencia;
   assign bus.BLOQUEO              = bloqueo;
endmodule

// File: tb/tb_cajero_param.sv
// tb/tb_cajero_param.sv - directed checks of cajero_param in default and 6-digit/16-bit builds
module tb_cajero_param;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   cajero_param_if ia ();
   cajero_param_if #(.PIN_DIGITS(6), .MONTO_W(16), .BALANCE_W(16)) ib ();

   cajero_param dut_a (.clk(clk), .rst(rst), .bus(ia));
   cajero_param #(.PIN_DIGITS(6), .MAX_INTENTOS(2), .MONTO_W(16), .BALANCE_W(16))
      dut_b (.clk(clk), .rst(rst), .bus(ib));

   int n_total = 0;
   int n_pass  = 0;
   int cnt_act = 0, cnt_ent = 0, cnt_fon = 0;

   always @(negedge clk) begin
      if (ia.BALANCE_ACTUALIZADO)  cnt_act++;
      if (ia.ENTREGAR_DINERO)      cnt_ent++;
      if (ia.FONDOS_INSUFICIENTES) cnt_fon++;
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask

   task automatic insert_a(input logic t);
      @(negedge clk);
      ia.TARJETA_RECIBIDA = 1'b1;
      ia.TIPO_TRANS = t;
   endtask

   task automatic pin_a(input logic [15:0] p);
      for (int i = 3; i >= 0; i--) begin
         @(negedge clk);
         ia.DIGITO_STB = 1'b1;
         ia.DIGITO = p[4*i +: 4];
      end
      @(negedge clk);
      ia.DIGITO_STB = 1'b0;
      @(negedge clk);
   endtask

   task automatic monto_a(input logic [31:0] m);
      @(negedge clk);
      ia.MONTO_STB = 1'b1;
      ia.MONTO = m;
      @(negedge clk);
      ia.MONTO_STB = 1'b0;
      @(negedge clk);
   endtask

   task automatic remove_a();
      @(negedge clk);
      ia.TARJETA_RECIBIDA = 1'b0;
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic pin_b(input logic [23:0] p);
      for (int i = 5; i >= 0; i--) begin
         @(negedge clk);
         ib.DIGITO_STB = 1'b1;
         ib.DIGITO = p[4*i +: 4];
      end
      @(negedge clk);
      ib.DIGITO_STB = 1'b0;
      @(negedge clk);
   endtask

   typedef struct {
      logic        tipo;
      logic [31:0] monto;
      logic [63:0] bal;
      int          act, ent, fon;
   } vec_t;
   vec_t vecs[6];

   initial begin
      int b_act, b_ent, b_fon;
      vecs[0] = '{1'b0,   500, 20500, 1, 0, 0};
      vecs[1] = '{1'b1, 15000,  5500, 1, 1, 0};
      vecs[2] = '{1'b1,  6000,  5500, 0, 0, 1};
      vecs[3] = '{1'b1,  5500,     0, 1, 1, 0};
      vecs[4] = '{1'b1,     1,     0, 0, 0, 1};
      vecs[5] = '{1'b0,     7,     7, 1, 0, 0};

      ia.TARJETA_RECIBIDA = 0; ia.TIPO_TRANS = 0; ia.DIGITO = 0; ia.DIGITO_STB = 0;
      ia.MONTO = 0; ia.MONTO_STB = 0; ia.PIN = 16'h1194; ia.BALANCE_INICIAL = 64'd20000;
      ib.TARJETA_RECIBIDA = 0; ib.TIPO_TRANS = 0; ib.DIGITO = 0; ib.DIGITO_STB = 0;
      ib.MONTO = 0; ib.MONTO_STB = 0; ib.PIN = 24'h123456; ib.BALANCE_INICIAL = 16'hFFF0;

      @(negedge clk);
      chk("reset_balance", ia.BALANCE, 0);
      chk("reset_bloqueo", ia.BLOQUEO, 0);
      chk("reset_advert", ia.ADVERTENCIA, 0);
      rst = 1'b1;
      @(negedge clk);
      chk("load_balance", ia.BALANCE, 20000);

      for (int v = 0; v < 6; v++) begin
         b_act = cnt_act; b_ent = cnt_ent; b_fon = cnt_fon;
         insert_a(vecs[v].tipo);
         pin_a(16'h1194);
         monto_a(vecs[v].monto);
         remove_a();
         chk($sformatf("vec%0d_balance", v), ia.BALANCE, vecs[v].bal);
         chk($sformatf("vec%0d_act", v), cnt_act - b_act, vecs[v].act);
         chk($sformatf("vec%0d_ent", v), cnt_ent - b_ent, vecs[v].ent);
         chk($sformatf("vec%0d_fon", v), cnt_fon - b_fon, vecs[v].fon);
      end

      insert_a(1'b0);
      pin_a(16'h1195);
      chk("persist_w1_advert", ia.ADVERTENCIA, 0);
      pin_a(16'h1195);
      chk("persist_w2_advert", ia.ADVERTENCIA, 1);
      remove_a();
      insert_a(1'b0);
      pin_a(16'h1194);
      chk("persist_advert_cleared", ia.ADVERTENCIA, 0);
      monto_a(100);
      chk("persist_deposit", ia.BALANCE, 107);
      remove_a();

      b_act = cnt_act; b_ent = cnt_ent; b_fon = cnt_fon;
      insert_a(1'b0);
      pin_a(16'h1194);
      @(negedge clk);
      ia.MONTO_STB = 1'b1;
      ia.MONTO = 999;
      ia.TARJETA_RECIBIDA = 1'b0;
      @(negedge clk);
      ia.MONTO_STB = 1'b0;
      repeat (3) @(negedge clk);
      chk("abort_balance", ia.BALANCE, 107);
      chk("abort_pulses", (cnt_act - b_act) + (cnt_ent - b_ent) + (cnt_fon - b_fon), 0);

      insert_a(1'b1);
      pin_a(16'h1195);
      chk("lock_a1_pin_inc", ia.PIN_INCORRECTO, 1);
      chk("lock_a1_advert", ia.ADVERTENCIA, 0);
      @(negedge clk);
      chk("lock_pulse_width", ia.PIN_INCORRECTO, 0);
      pin_a(16'h1195);
      chk("lock_a2_pin_inc", ia.PIN_INCORRECTO, 1);
      chk("lock_a2_advert", ia.ADVERTENCIA, 1);
      chk("lock_a2_bloqueo", ia.BLOQUEO, 0);
      pin_a(16'h1195);
      chk("lock_a3_bloqueo", ia.BLOQUEO, 1);
      b_act = cnt_act;
      pin_a(16'h1194);
      monto_a(10);
      chk("lock_ignored_pin_inc", ia.PIN_INCORRECTO, 0);
      chk("lock_ignored_balance", ia.BALANCE, 107);
      chk("lock_ignored_act", cnt_act - b_act, 0);
      chk("lock_holds", ia.BLOQUEO, 1);
      remove_a();

      rst = 1'b0;
      #1;
      chk("async_reset_bloqueo", ia.BLOQUEO, 0);
      chk("async_reset_balance", ia.BALANCE, 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("reload_balance", ia.BALANCE, 20000);
      chk("b_load_balance", ib.BALANCE, 16'hFFF0);

      @(negedge clk);
      ib.TARJETA_RECIBIDA = 1'b1;
      ib.TIPO_TRANS = 1'b0;
      pin_b(24'h123456);
      @(negedge clk);
      ib.MONTO_STB = 1'b1;
      ib.MONTO = 16'h0020;
      @(negedge clk);
      ib.MONTO_STB = 1'b0;
      @(negedge clk);
      chk("b_saturate", ib.BALANCE, 16'hFFFF);
      chk("b_act_pulse", ib.BALANCE_ACTUALIZADO, 1);
      @(negedge clk);
      ib.TARJETA_RECIBIDA = 1'b0;
      repeat (2) @(negedge clk);
      ib.TARJETA_RECIBIDA = 1'b1;
      pin_b(24'h123457);
      chk("b_w1_advert", ib.ADVERTENCIA, 1);
      chk("b_w1_bloqueo", ib.BLOQUEO, 0);
      pin_b(24'h123457);
      chk("b_w2_bloqueo", ib.BLOQUEO, 1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
